key_pulse: RTL
==============

Name: key_pulse

Overview:
- Conditions the raw board buttons into clean control events for the on-board test bodies, which take them on cs/we/high-style inputs. Sits between the button pads and the test body.
- Per channel, in order: 2-flop synchroniser, debounce counter, press/release event generator, optional hold-to-repeat.
- Gives single-cycle command strobes, so a test body fires exactly one bus transaction per press instead of acting on a held level.

Parameters:
- CHANNELS, 4, number of independent button channels.
- CLK_FREQ, 10, clock frequency in MHz; all time parameters are scaled by it.
- DEBOUNCE_US, 10000, stable time required before a level change is accepted. DB_CYC = max(1, CLK_FREQ*DEBOUNCE_US).
- REPEAT_DELAY_US, 500000, hold time before the first auto-repeat. RD_CYC = max(1, CLK_FREQ*REPEAT_DELAY_US).
- REPEAT_PERIOD_US, 100000, interval between auto-repeats. RP_CYC = max(1, CLK_FREQ*REPEAT_PERIOD_US).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  event enable; gates press and release only.
- btn_i  in  CHANNELS  raw button pads, asynchronous, active-high.
- level  out  CHANNELS  debounced button state.
- press  out  CHANNELS  one-cycle strobe on an accepted press, plus auto-repeats when that feature is compiled in.
- release  out  CHANNELS  one-cycle strobe on an accepted release.

Behaviour:
- Reset: on a rising edge with rst_n=0, all sync flops, level, press, release, counters and FSMs clear to 0/IDLE. Reset overrides every other event on that edge.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous strobes.
- Sync: s1<=btn_i; s2<=s1.
- Debounce, per channel, counter dcnt of width clog2(DB_CYC):
  - If s2==level: dcnt<=0.
  - Else if dcnt==DB_CYC-1: level<=s2 and dcnt<=0.
  - Else: dcnt<=dcnt+1.
  - Latency: when btn_i settles before edge E0, level flips at edge E(DB_CYC+1), i.e. DB_CYC+2 edges.
  - A glitch shorter than DB_CYC cycles at s2 causes no change.
- Events, all registered:
  - press=1 for exactly the cycle in which level first reads 1.
  - release=1 for exactly the cycle in which level first reads 0.
  - Both are ANDed with en as sampled on the edge that produces them.
  - level is never gated by en.
- A button held through reset release produces a press DB_CYC+2 cycles after rst_n rises.
- Event FSM per channel, states IDLE / HELD (plus DELAY / REPEAT when the optional feature is compiled in):
  - IDLE -> HELD on a level rise; press strobe.
  - Any state -> IDLE on a level fall, in the same edge as level clears; release strobe, repeat counter cleared.
- Counter widths are sized from the largest of DB_CYC, RD_CYC, RP_CYC. There is no wrap: counters always clear on reaching their terminal value.

Optional Feature:
- Macro: KEY_PULSE_REPEAT_EN.
- Defined:
  - A level rise goes IDLE -> DELAY (press strobe) and rcnt<=0.
  - In DELAY, rcnt counts; at rcnt==RD_CYC-1: press strobe, go to REPEAT, rcnt<=0.
  - In REPEAT: press strobe every RP_CYC cycles, rcnt<=0 on each.
  - Repeat strobes are gated by en; counting continues while en=0, so no catch-up burst occurs when en returns.
  - A level fall in DELAY or REPEAT goes to IDLE. A repeat due on that same edge is dropped.
- Undefined:
  - The DELAY/REPEAT states, rcnt, RD_CYC and RP_CYC logic are not built.
  - Exactly one press per accepted press, regardless of hold time.

Test Plan (CLK_FREQ=1, DEBOUNCE_US=4, REPEAT_DELAY_US=20, REPEAT_PERIOD_US=8, CHANNELS=4, en=1 unless stated; t=0 is the first edge sampling the new btn value):
- Glitch: btn_i[0]=1 for 3 cycles, then 0 -> level, press and release stay 0 throughout.
- Clean press, repeat undefined: btn_i[1]=1 held 40 cycles -> level[1] rises at t=5 with a single press[1] pulse at t=5. No further pulses. Other channels stay 0.
- Repeat defined: btn_i[2]=1 from t=0, released at t=50 -> press[2] pulses at t=5, 25, 33, 41, 49. level falls at t=55 with release[2] pulsing at t=55. No pulse at 57.
- Enable gating, repeat defined: en=0 during t=0..30 with btn_i[3] held -> level[3] rises at 5 with no press. en=1 at 31 -> next press at t=33, then 41.
- Simultaneous events: btn_i[0] and btn_i[1] rise in the same cycle -> both press bits pulse in the same cycle, t=5.
- Reset mid-repeat: rst_n=0 for one edge at t=30 with btn_i[2] held -> all outputs 0 on the next cycle. After reset, level[2] and press[2] rise again 6 edges after rst_n returns high.

Source files
------------

// File: rtl/key_pulse.sv
// Button conditioner: per-channel 2-flop sync, debounce, and press/release strobes.
// Define KEY_PULSE_REPEAT_EN to add hold-to-repeat press strobes.
module key_pulse #(
  parameter int unsigned CHANNELS         = 4,
  parameter int unsigned CLK_FREQ         = 10,
  parameter int unsigned DEBOUNCE_US      = 10000,
  parameter int unsigned REPEAT_DELAY_US  = 500000,
  parameter int unsigned REPEAT_PERIOD_US = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] btn_i,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_o
);

  localparam int unsigned DbCyc = (CLK_FREQ * DEBOUNCE_US > 0) ? CLK_FREQ * DEBOUNCE_US : 1;
  localparam int unsigned RdCyc = (CLK_FREQ * REPEAT_DELAY_US > 0) ?
                                  CLK_FREQ * REPEAT_DELAY_US : 1;
  localparam int unsigned RpCyc = (CLK_FREQ * REPEAT_PERIOD_US > 0) ?
                                  CLK_FREQ * REPEAT_PERIOD_US : 1;
  localparam int unsigned MaxCyc = (DbCyc > RdCyc) ? ((DbCyc > RpCyc) ? DbCyc : RpCyc) :
                                                     ((RdCyc > RpCyc) ? RdCyc : RpCyc);
  localparam int unsigned CntW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] DbLast = CntW'(DbCyc - 1);
`ifdef KEY_PULSE_REPEAT_EN
  localparam logic [CntW-1:0] RdLast = CntW'(RdCyc - 1);
  localparam logic [CntW-1:0] RpLast = CntW'(RpCyc - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StDelay, StRepeat} state_e;
`else
  typedef enum logic {StIdle, StHeld} state_e;
`endif

  logic [CHANNELS-1:0] s1_q, s2_q;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = release_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CntW-1:0] dcnt_q, dcnt_d;
    logic            lvl_nxt, rise, fall, due;
    state_e          state_q, state_d;
`ifdef KEY_PULSE_REPEAT_EN
    logic [CntW-1:0] rcnt_q, rcnt_d;
`endif

    // Level flips only after s2 has disagreed with it for DbCyc consecutive edges.
    always_comb begin
      dcnt_d  = dcnt_q;
      lvl_nxt = level_q[i];
      rise    = 1'b0;
      fall    = 1'b0;
      if (s2_q[i] == level_q[i]) begin
        dcnt_d = '0;
      end else if (dcnt_q == DbLast) begin
        lvl_nxt = s2_q[i];
        dcnt_d  = '0;
        rise    = s2_q[i];
        fall    = ~s2_q[i];
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dcnt_q  <= '0;
        state_q <= StIdle;
`ifdef KEY_PULSE_REPEAT_EN
        rcnt_q  <= '0;
`endif
      end else begin
        dcnt_q  <= dcnt_d;
        state_q <= state_d;
`ifdef KEY_PULSE_REPEAT_EN
        rcnt_q  <= rcnt_d;
`endif
      end
    end

    always_comb begin
      state_d = state_q;
`ifdef KEY_PULSE_REPEAT_EN
      rcnt_d  = rcnt_q;
`endif
      if (fall) begin
        state_d = StIdle;
`ifdef KEY_PULSE_REPEAT_EN
        rcnt_d  = '0;
`endif
      end else begin
        case (state_q)
          StIdle: begin
            if (rise) begin
`ifdef KEY_PULSE_REPEAT_EN
              state_d = StDelay;
              rcnt_d  = '0;
`else
              state_d = StHeld;
`endif
            end
          end
`ifdef KEY_PULSE_REPEAT_EN
          StDelay: begin
            if (rcnt_q == RdLast) begin
              state_d = StRepeat;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          StRepeat: begin
            if (rcnt_q == RpLast) rcnt_d = '0;
            else                  rcnt_d = rcnt_q + 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end

    // Counting is never gated; en only masks the strobes, so no catch-up burst.
    always_comb begin
      due = 1'b0;
      case (state_q)
        StIdle:   due = rise;
`ifdef KEY_PULSE_REPEAT_EN
        StDelay:  due = (rcnt_q == RdLast) & ~fall;
        StRepeat: due = (rcnt_q == RpLast) & ~fall;
`endif
        default:  due = 1'b0;
      endcase
    end

    assign level_d[i]   = lvl_nxt;
    assign press_d[i]   = due & en;
    assign release_d[i] = fall & en;
  end

endmodule
